// File: rtl/pic_dispatch_pkg.sv
// pic_dispatch_pkg
// Shared definitions for the interrupt dispatch sequencer:
//   - disp_state_e : dispatcher FSM states
//   - PIC_ADR_*    : register addresses of the upstream simple_pic
//   - VEC_W        : width of the CPU interrupt vector
package pic_dispatch_pkg;

    localparam int VEC_W = 8;

    localparam logic [1:0] PIC_ADR_EDGEN = 2'b00;
    localparam logic [1:0] PIC_ADR_POL   = 2'b01;
    localparam logic [1:0] PIC_ADR_MASK  = 2'b10;
    localparam logic [1:0] PIC_ADR_PEND  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_PEND  = 3'd1,
        ST_PRESENT  = 3'd2,
        ST_SERVICE  = 3'd3,
        ST_CLR_PEND = 3'd4,
        ST_HOLDOFF  = 3'd5
    } disp_state_e;

endpackage

// File: rtl/pic_prio_enc.sv
// pic_prio_enc
// Combinational 8-bit priority encoder with a movable starting point.
// The search begins at bit 'start' and walks upward, wrapping modulo 8;
// the first set bit found is reported.
// Ports:
//   req   in  8 : request bits
//   start in  3 : bit position with the highest priority
//   idx   out 3 : index of the selected bit (0 when none)
//   valid out 1 : at least one request bit is set
module pic_prio_enc (
    input  logic [7:0] req,
    input  logic [2:0] start,
    output logic [2:0] idx,
    output logic       valid
);

    // Walk from the lowest priority offset to the highest so the
    // last assignment made is the winning one.
    always_comb begin
        idx   = 3'd0;
        valid = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (req[start + 3'(i)]) begin
                idx   = start + 3'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pic_irq_dispatcher.sv
// pic_irq_dispatcher
// Sits behind simple_pic. When the PIC raises its interrupt line, reads the
// PENDING register over Wishbone, picks one source, presents a vector to the
// CPU, waits for end-of-interrupt and then clears that source in PENDING.
//
// Optional feature: define PIC_DISPATCH_RR_EN for rotating priority (search
// starts after the last serviced index). Without it, bit 0 always wins.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-low reset
//   int_i                   PIC interrupt line
//   m_cyc_o .. m_ack_i      Wishbone master to the PIC register port
//   irq_req_o, irq_vec_o    vector request to the CPU
//   irq_ack_i, eoi_i        CPU take / end-of-interrupt
//   busy_o                  FSM not idle
//   err_o, err_clr_i        sticky bus-timeout flag and its clear
//
// Handshakes: a Wishbone cycle holds cyc/stb/we/adr/dat constant until ack is
// sampled high, then drops them on the following edge. irq_req_o holds with a
// stable irq_vec_o until irq_ack_i is sampled high, then drops on the next edge.
module pic_irq_dispatcher
    import pic_dispatch_pkg::*;
#(
    parameter logic [7:0] VEC_BASE    = 8'h20,
    parameter int         ACK_TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             int_i,
    output logic             m_cyc_o,
    output logic             m_stb_o,
    output logic             m_we_o,
    output logic [1:0]       m_adr_o,
    output logic [7:0]       m_dat_o,
    input  logic [7:0]       m_dat_i,
    input  logic             m_ack_i,
    output logic             irq_req_o,
    output logic [VEC_W-1:0] irq_vec_o,
    input  logic             irq_ack_i,
    input  logic             eoi_i,
    output logic             busy_o,
    output logic             err_o,
    input  logic             err_clr_i
);

    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    disp_state_e      state_q, state_d;
    logic             cyc_q, cyc_d;
    logic             we_q, we_d;
    logic [1:0]       adr_q, adr_d;
    logic [7:0]       dat_q, dat_d;
    logic             req_q, req_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [2:0]       idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             err_set;
    logic [7:0]       tmo_q, tmo_d;
    logic             hold_q, hold_d;

    logic [2:0]       enc_idx;
    logic             enc_valid;
    logic [2:0]       enc_start;

`ifdef PIC_DISPATCH_RR_EN
    logic [2:0] last_q, last_d;
    assign enc_start = last_q + 3'd1;
`else
    assign enc_start = 3'd0;
`endif

    pic_prio_enc u_enc (
        .req   (m_dat_i),
        .start (enc_start),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        req_d   = req_q;
        vec_d   = vec_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        hold_d  = hold_q;
        err_set = 1'b0;
`ifdef PIC_DISPATCH_RR_EN
        last_d  = last_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (int_i) begin
                    state_d = ST_RD_PEND;
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                    adr_d   = PIC_ADR_PEND;
                    dat_d   = 8'h00;
                    tmo_d   = 8'd0;
                end
            end

            ST_RD_PEND: begin
                if (m_ack_i) begin
                    cyc_d = 1'b0;
                    adr_d = PIC_ADR_EDGEN;
                    if (enc_valid) begin
                        idx_d   = enc_idx;
                        vec_d   = VEC_BASE + {5'd0, enc_idx};
                        req_d   = 1'b1;
                        state_d = ST_PRESENT;
                    end else begin
                        // Line was high but nothing is pending: spurious.
                        state_d = ST_HOLDOFF;
                        hold_d  = 1'b0;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    cyc_d   = 1'b0;
                    adr_d   = PIC_ADR_EDGEN;
                    err_set = 1'b1;
                    state_d = ST_HOLDOFF;
                    hold_d  = 1'b0;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end

            ST_PRESENT: begin
                if (irq_ack_i) begin
                    req_d   = 1'b0;
                    state_d = ST_SERVICE;
                end
            end

            ST_SERVICE: begin
                if (eoi_i) begin
                    state_d = ST_CLR_PEND;
                    cyc_d   = 1'b1;
                    we_d    = 1'b1;
                    adr_d   = PIC_ADR_PEND;
                    dat_d   = 8'h01 << idx_q;
                    tmo_d   = 8'd0;
                end
            end

            ST_CLR_PEND: begin
                if (m_ack_i || (tmo_q == TMO_LAST)) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    adr_d   = PIC_ADR_EDGEN;
                    dat_d   = 8'h00;
                    state_d = ST_HOLDOFF;
                    hold_d  = 1'b0;
                    if (m_ack_i) begin
`ifdef PIC_DISPATCH_RR_EN
                        last_d = idx_q;
`endif
                    end else begin
                        // Source stays pending in the PIC and will re-fire.
                        err_set = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end

            ST_HOLDOFF: begin
                // Two cycles so the PIC's registered int_o reflects the clear.
                if (hold_q) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                we_d    = 1'b0;
                req_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        // A timeout in the same cycle as a clear request keeps the flag set.
        err_d  = err_set | (err_q & ~err_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 2'b00;
            dat_q   <= 8'h00;
            req_q   <= 1'b0;
            vec_q   <= '0;
            idx_q   <= 3'd0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 8'd0;
            hold_q  <= 1'b0;
`ifdef PIC_DISPATCH_RR_EN
            last_q  <= 3'd7;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            req_q   <= req_d;
            vec_q   <= vec_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            hold_q  <= hold_d;
`ifdef PIC_DISPATCH_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign m_cyc_o   = cyc_q;
    assign m_stb_o   = cyc_q;
    assign m_we_o    = we_q;
    assign m_adr_o   = adr_q;
    assign m_dat_o   = dat_q;
    assign irq_req_o = req_q;
    assign irq_vec_o = vec_q;
    assign busy_o    = busy_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_pic_irq_dispatcher.sv
// tb_pic_irq_dispatcher
// Bench for pic_irq_dispatcher: a small PIC model answers the Wishbone port,
// a CPU process takes vectors and issues end-of-interrupt, and a transaction
// level reference model checks every output on every cycle.
module tb_pic_irq_dispatcher;

    localparam logic [7:0] VEC_BASE    = 8'h20;
    localparam int         ACK_TIMEOUT = 16;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       int_i;
    logic       m_cyc_o, m_stb_o, m_we_o;
    logic [1:0] m_adr_o;
    logic [7:0] m_dat_o;
    logic [7:0] m_dat_i;
    logic       m_ack_i;
    logic       irq_req_o;
    logic [7:0] irq_vec_o;
    logic       irq_ack_i;
    logic       eoi_i;
    logic       busy_o;
    logic       err_o;
    logic       err_clr_i;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    pic_irq_dispatcher #(.VEC_BASE(VEC_BASE), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .int_i     (int_i),
        .m_cyc_o   (m_cyc_o),
        .m_stb_o   (m_stb_o),
        .m_we_o    (m_we_o),
        .m_adr_o   (m_adr_o),
        .m_dat_o   (m_dat_o),
        .m_dat_i   (m_dat_i),
        .m_ack_i   (m_ack_i),
        .irq_req_o (irq_req_o),
        .irq_vec_o (irq_vec_o),
        .irq_ack_i (irq_ack_i),
        .eoi_i     (eoi_i),
        .busy_o    (busy_o),
        .err_o     (err_o),
        .err_clr_i (err_clr_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- PIC model ----------------
    logic [7:0] pend_q = 8'h00;
    logic [7:0] rdat_q = 8'h00;
    logic       ack_q  = 1'b0;
    logic       int_q  = 1'b0;
    int         wait_cnt = 0;
    logic [7:0] raise_bits = 8'h00;
    logic [7:0] clr_v, rnd_v;
    bit ack_block = 0, stall_en = 0, spur_mode = 0, rand_raise = 0, stray_en = 0;

    always @(posedge clk_i) begin
        clr_v = (ack_q && m_cyc_o && m_stb_o && m_we_o && m_adr_o == 2'b11) ? m_dat_o : 8'h00;
        rnd_v = 8'h00;
        if (rand_raise && $urandom_range(0, 15) == 0)
            rnd_v = 8'h01 << $urandom_range(0, 7);
        pend_q <= (pend_q & ~clr_v) | raise_bits | rnd_v;
        int_q  <= spur_mode ? 1'b1 : (|pend_q);
        ack_q  <= 1'b0;
        if (m_cyc_o && m_stb_o && !ack_q && !ack_block) begin
            if (wait_cnt > 0) begin
                wait_cnt <= wait_cnt - 1;
            end else begin
                ack_q    <= 1'b1;
                rdat_q   <= spur_mode ? 8'h00 : pend_q;
                wait_cnt <= stall_en ? int'($urandom_range(0, 3)) : 0;
            end
        end
    end

    assign m_ack_i = ack_q;
    assign m_dat_i = rdat_q;
    assign int_i   = int_q;

    task automatic raise(input logic [7:0] v);
        raise_bits = v;
        @(posedge clk_i);
        #1 raise_bits = 8'h00;
    endtask

    // ---------------- CPU model ----------------
    initial begin
        irq_ack_i = 1'b0;
        eoi_i     = 1'b0;
        forever begin
            @(negedge clk_i);
            if (irq_req_o) begin
                repeat ($urandom_range(0, 3)) @(posedge clk_i);
                @(posedge clk_i); #1 irq_ack_i = 1'b1;
                @(posedge clk_i); #1 irq_ack_i = 1'b0;
                repeat ($urandom_range(0, 4)) @(posedge clk_i);
                @(posedge clk_i); #1 eoi_i = 1'b1;
                @(posedge clk_i); #1 eoi_i = 1'b0;
            end else if (stray_en && $urandom_range(0, 31) == 0) begin
                @(posedge clk_i); #1 eoi_i = 1'b1;
                @(posedge clk_i); #1 eoi_i = 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [2:0] sel(input logic [7:0] d, input logic [2:0] last);
        int s;
        s = 0;
`ifdef PIC_DISPATCH_RR_EN
        s = (int'(last) + 1) % 8;
`endif
        for (int k = 0; k < 8; k++)
            if (d[(s + k) % 8]) return 3'((s + k) % 8);
        return 3'd0;
    endfunction

    bit         m_idle = 1, m_present = 0, m_service = 0, m_err = 0, m_tmo = 0;
    int         m_bus = 0, m_len = 0, m_hold = -1;
    logic [2:0] m_idx = 3'd0, m_last = 3'd7;
    logic [7:0] m_vec = 8'h00;
    bit         p_valid = 0;
    logic       p_rst, p_int, p_ack, p_irq_ack, p_eoi, p_err_clr;
    logic [7:0] p_dat;

    always @(negedge clk_i) begin
        if (p_valid) begin
            if (!p_rst) begin
                m_idle = 1; m_present = 0; m_service = 0; m_err = 0;
                m_bus = 0; m_len = 0; m_hold = -1; m_last = 3'd7;
                check("rst_adr", 32'(m_adr_o), 32'h0);
                check("rst_dat", 32'(m_dat_o), 32'h0);
                check("rst_vec", 32'(irq_vec_o), 32'h0);
            end else begin
                m_tmo = 0;
                if (m_bus != 0) begin
                    if (p_ack) begin
                        if (m_bus == 1 && p_dat != 8'h00) begin
                            m_idx = sel(p_dat, m_last);
                            m_vec = VEC_BASE + 8'(m_idx);
                            m_present = 1;
                        end else begin
                            if (m_bus == 2) m_last = m_idx;
                            m_hold = 0;
                        end
                        m_bus = 0;
                    end else if (m_len == ACK_TIMEOUT) begin
                        m_tmo = 1; m_bus = 0; m_hold = 0;
                    end else begin
                        m_len++;
                    end
                end else if (m_present) begin
                    if (p_irq_ack) begin m_present = 0; m_service = 1; end
                end else if (m_service) begin
                    if (p_eoi) begin m_service = 0; m_bus = 2; m_len = 1; end
                end else if (m_hold >= 0) begin
                    m_hold++;
                    if (m_hold == 2) begin m_hold = -1; m_idle = 1; end
                end else if (m_idle) begin
                    if (p_int) begin m_idle = 0; m_bus = 1; m_len = 1; end
                end
                if (m_tmo) m_err = 1;
                else if (p_err_clr) m_err = 0;
            end
            check("cyc", 32'(m_cyc_o), 32'(m_bus != 0));
            check("stb", 32'(m_stb_o), 32'(m_bus != 0));
            check("we", 32'(m_we_o), 32'(m_bus == 2));
            if (m_bus != 0) check("adr", 32'(m_adr_o), 32'h3);
            if (m_bus == 2) check("wdat", 32'(m_dat_o), 32'(8'h01 << m_idx));
            check("irq_req", 32'(irq_req_o), 32'(m_present));
            if (m_present) check("irq_vec", 32'(irq_vec_o), 32'(m_vec));
            check("busy", 32'(busy_o), 32'(!m_idle));
            check("err", 32'(err_o), 32'(m_err));
        end
        p_rst = rst_i; p_int = int_i; p_ack = m_ack_i; p_irq_ack = irq_ack_i;
        p_eoi = eoi_i; p_err_clr = err_clr_i; p_dat = m_dat_i;
        p_valid = 1;
    end

    // ---------------- directed + random sequence ----------------
    function automatic bit cond(input int w);
        case (w)
            0: return irq_req_o;
            1: return m_cyc_o && m_we_o;
            2: return !busy_o && pend_q == 8'h00 && !int_i;
            3: return m_cyc_o && m_we_o && m_ack_i;
            4: return m_cyc_o && !m_we_o && m_ack_i;
            5: return m_cyc_o;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input string name, input int w, input int budget);
        int k;
        k = 0;
        while (!cond(w) && k < budget) begin
            @(negedge clk_i);
            k++;
        end
        n_tests++;
        if (!cond(w)) begin
            n_fail++;
            $display("FAIL %s: condition not reached within %0d cycles", name, budget);
        end
    endtask

    int cnt;
    int block_cnt;

    initial begin
        rst_i = 1'b0; err_clr_i = 1'b0;

        // Reset with int_i high: no bus activity, outputs at reset values.
        raise(8'h04);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_int_high", 32'(int_i), 32'h1);
        check("rst_cyc", 32'(m_cyc_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_req", 32'(irq_req_o), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        @(posedge clk_i); #1 rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("rel_cyc", 32'(m_cyc_o), 32'h1);
        check("rel_adr", 32'(m_adr_o), 32'h3);
        check("rel_we", 32'(m_we_o), 32'h0);

        // Single source at bit 2.
        wait_for("a_req", 0, 10);
        check("a_vec", 32'(irq_vec_o), 32'h22);
        wait_for("a_wr", 1, 30);
        check("a_wadr", 32'(m_adr_o), 32'h3);
        check("a_wdat", 32'(m_dat_o), 32'h04);
        wait_for("a_drain", 2, 40);

        // Two sources, pending read 8'b1000_0010, served twice.
        @(posedge clk_i); #1 rst_i = 1'b0;
        raise(8'h82);
        @(posedge clk_i); #1 rst_i = 1'b1;
        wait_for("b_req1", 0, 20);
        check("b_vec1", 32'(irq_vec_o), 32'h21);
        wait_for("b_wack1", 3, 30);
        @(posedge clk_i); #1;
        raise(8'h02);
        wait_for("b_req2", 0, 30);
`ifdef PIC_DISPATCH_RR_EN
        check("b_vec2", 32'(irq_vec_o), 32'h27);
`else
        check("b_vec2", 32'(irq_vec_o), 32'h21);
`endif
        wait_for("b_drain", 2, 100);

        // Spurious: line high, PENDING reads zero.
        @(posedge clk_i); #1 spur_mode = 1;
        wait_for("c_rd", 4, 20);
        @(posedge clk_i); #1 spur_mode = 0;
        @(negedge clk_i);
        check("c_hold_busy", 32'(busy_o), 32'h1);
        check("c_req0", 32'(irq_req_o), 32'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        check("c_idle", 32'(busy_o), 32'h0);
        repeat (3) @(negedge clk_i);
        check("c_stay_idle", 32'(m_cyc_o), 32'h0);
        check("c_req1", 32'(irq_req_o), 32'h0);

        // Bus timeout: PIC never acks.
        ack_block = 1;
        raise(8'h10);
        wait_for("d_cyc", 5, 20);
        cnt = 0;
        while (m_cyc_o && cnt < 40) begin
            cnt++;
            @(negedge clk_i);
        end
        check("d_cyc_len", 32'(cnt), 32'd16);
        check("d_err_set", 32'(err_o), 32'h1);
        check("d_busy", 32'(busy_o), 32'h1);
        ack_block = 0;
        wait_for("d_drain", 2, 200);
        check("d_err_sticky", 32'(err_o), 32'h1);
        @(posedge clk_i); #1 err_clr_i = 1'b1;
        @(posedge clk_i); #1 err_clr_i = 1'b0;
        @(negedge clk_i);
        check("d_err_clr", 32'(err_o), 32'h0);

        // Random traffic with stalls, stray EOIs, blocked acks and a mid-run reset.
        stall_en = 1; rand_raise = 1; stray_en = 1;
        block_cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk_i); #1;
            err_clr_i = ($urandom_range(0, 63) == 0);
            if (block_cnt > 0) begin
                block_cnt--;
                if (block_cnt == 0) ack_block = 0;
            end else if ($urandom_range(0, 399) == 0) begin
                ack_block = 1;
                block_cnt = $urandom_range(10, 30);
            end
            rst_i = !(c >= 2000 && c < 2002);
        end
        err_clr_i = 1'b0; ack_block = 0; rand_raise = 0; stray_en = 0; rst_i = 1'b1;
        wait_for("r_drain", 2, 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pic_irq_dispatcher.md
# pic_irq_dispatcher

Interrupt dispatch sequencer sitting directly downstream of `simple_pic`. It consumes the PIC's `int_o` and, as a Wishbone master on the PIC's register port, reads the PENDING register and selects one source. It presents a vector to the CPU with a request/acknowledge handshake, waits for end-of-interrupt, then writes the PIC's PENDING register to clear that source.

## Interface
Parameters:
- `VEC_BASE`, 8'h20: vector base; `irq_vec_o = VEC_BASE + index`, modulo 256.
- `ACK_TIMEOUT`, 16: maximum cycles to wait for `m_ack_i` per bus cycle; range 2..255.

Ports:
- `clk_i` in 1: the single clock; everything samples on the rising edge.
- `rst_i` in 1: reset; synchronous and active-low (0 = reset).
- `int_i` in 1: interrupt line from the PIC's `int_o`.
- `m_cyc_o` in/out: out 1, Wishbone cycle to the PIC.
- `m_stb_o` out 1: Wishbone strobe.
- `m_we_o` out 1: Wishbone write enable.
- `m_adr_o` out 2: PIC register address.
- `m_dat_o` out 8: write data.
- `m_dat_i` in 8: read data (PIC `dat_o`).
- `m_ack_i` in 1: PIC `ack_o`.
- `irq_req_o` out 1: vector valid, request to the CPU.
- `irq_vec_o` out 8: interrupt vector.
- `irq_ack_i` in 1: CPU has taken the vector.
- `eoi_i` in 1: CPU end-of-interrupt pulse.
- `busy_o` out 1: FSM not in IDLE.
- `err_o` out 1: sticky bus-timeout flag.
- `err_clr_i` in 1: clears `err_o`.

## Operation
- PIC register map, used as constants: 2'b00 EDGE_EN, 2'b01 POL, 2'b10 MASK, 2'b11 PENDING.
  - A read of PENDING returns the pending bits.
  - A write to PENDING clears each bit written as 1.
- FSM states: IDLE, RD_PEND, PRESENT, SERVICE, CLR_PEND, HOLDOFF.
- IDLE: if `int_i == 1`, go to RD_PEND.
- RD_PEND: drive `cyc=stb=1`, `we=0`, `adr=2'b11` until `m_ack_i`. On ack, capture `m_dat_i`:
  - If the captured value is 0: spurious interrupt; go to HOLDOFF.
  - Otherwise: select index `idx`, register `irq_vec_o = VEC_BASE+idx`, assert `irq_req_o`, go to PRESENT.
- PRESENT: hold `irq_req_o` and `irq_vec_o` stable until `irq_ack_i`. Then drop `irq_req_o` and go to SERVICE.
- SERVICE: wait for `eoi_i`, then go to CLR_PEND. An `eoi_i` arriving in any other state is ignored.
- CLR_PEND: drive `cyc=stb=we=1`, `adr=2'b11`, `m_dat_o = 1<<idx` until `m_ack_i`. Then go to HOLDOFF.
- HOLDOFF: stay 2 cycles, ignoring `int_i` so the PIC's registered `int_o` can settle, then go to IDLE.
- Bus timeout: a counter starts at each bus cycle.
  - If `m_ack_i` has not arrived after `ACK_TIMEOUT` cycles, drop `cyc/stb/we`, set `err_o`, and go to HOLDOFF.
  - A CLR_PEND timeout leaves the source pending; it will re-fire.
- `err_o`: set by a timeout, cleared by `err_clr_i`. If both happen in the same cycle, set wins.
- Selection: fixed priority, lowest set bit wins (see Configuration).
- Reset mid-operation: all state is abandoned at the next edge.
  - Bus signals drop immediately on the registered outputs.
  - The PIC's PENDING register is untouched, so a pending source re-triggers after reset.

## Timing
- All outputs are registered. Reset values: `m_cyc_o=0`, `m_stb_o=0`, `m_we_o=0`, `m_adr_o=2'b00`, `m_dat_o=8'h00`, `irq_req_o=0`, `irq_vec_o=8'h00`, `busy_o=0`, `err_o=0`.
- `int_i` sampled high in IDLE → `m_cyc_o/m_stb_o` high on the next edge.
- Bus cycle:
  - `cyc`, `stb`, `adr`, `we` and `dat` are held constant until `m_ack_i` is sampled high.
  - They deassert on the following edge.
  - No back-to-back cycles: at least one idle cycle separates RD_PEND and CLR_PEND.
- Read ack sampled → `irq_req_o` high on the next edge. Total with the PIC's one-cycle ack: `int_i` to `irq_req_o` is 3 cycles.
- `irq_ack_i` sampled while `irq_req_o=1` → `irq_req_o=0` on the next edge.
- `eoi_i` sampled in SERVICE → CLR_PEND bus cycle starts on the next edge.
- `busy_o` is 1 in every state except IDLE.

## Configuration
- `PIC_DISPATCH_RR_EN`:
  - **Defined:** rotating priority. A `last_idx` register (reset 7) records the last index serviced. The search starts at `last_idx+1` and wraps modulo 8. `last_idx` updates when CLR_PEND completes.
  - **Undefined:** fixed priority (bit 0 highest), and no `last_idx` register exists.

## Structure
- Package `pic_dispatch_pkg` holds:
  - the FSM state enum;
  - the PIC address constants (`PIC_ADR_EDGEN`, `PIC_ADR_POL`, `PIC_ADR_MASK`, `PIC_ADR_PEND`);
  - the vector-width constant (8).
- Sub-module `pic_prio_enc`: combinational 8-bit priority encoder.
  - Inputs: `req[7:0]` and `start[2:0]`. Outputs: `idx[2:0]` and `valid`.
  - `start` is tied to 0 unless `PIC_DISPATCH_RR_EN` is defined.

## Test plan
- Reset held low for 3 cycles with `int_i=1` → all outputs at their reset values and no bus activity. After release, RD_PEND starts on the next edge.
- PENDING reads 8'b0000_0100 → `irq_vec_o=8'h22`, `irq_req_o=1`. Drive `irq_ack_i` then `eoi_i` → a write to `adr=2'b11` with `dat=8'h04`, then IDLE.
- PENDING reads 8'b1000_0010 with fixed priority → vector 8'h21.
- Round-robin (`PIC_DISPATCH_RR_EN`): the same read twice → vectors 8'h21, then 8'h27.
- `int_i=1` but PENDING reads 8'h00 → no `irq_req_o`. After HOLDOFF (2 cycles), back to IDLE.
- `m_ack_i` held low → bus dropped after 16 cycles, `err_o=1` stays set, and `err_clr_i` clears it.
